// File: rtl/data_in_if.sv
// data_in_if: byte stream in, assembled frame out, for the LDPC input deserializer
interface data_in_if #(
  parameter int N  = 9216,
  parameter int W  = 8,
  parameter int CW = 11
);
  logic          din_valid;
  logic          sof;
  logic [W-1:0]  d_in;
  logic          din_ready;
  logic [N-1:0]  v_in;
  logic          v_valid;
  logic          v_ready;
  logic [CW-1:0] count_in;
  logic          sync_err;
  modport master (
    output din_valid, sof, d_in, v_ready,
    input  din_ready, v_in, v_valid, count_in, sync_err
  );
  modport slave (
    input  din_valid, sof, d_in, v_ready,
    output din_ready, v_in, v_valid, count_in, sync_err
  );
endinterface

// File: rtl/data_in.sv
// data_in: packs NB bytes (byte 0 lowest) into an N-bit frame and holds it for the decoder core
module data_in #(
  parameter int N  = 9216,
  parameter int W  = 8,
  parameter int CW = 11
) (
  input logic     clk,
  input logic     rst_n,
  data_in_if.slave bus
);
  localparam int NB = N / W;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  logic [1:0]    state;
  logic [N-1:0]  vin;
  logic [CW-1:0] cnt;
  logic          err;
  logic          xfer;
  assign xfer          = bus.din_valid && bus.din_ready;
  assign bus.din_ready = state != HOLD;
  assign bus.v_valid   = state == HOLD;
  assign bus.v_in      = vin;
  assign bus.count_in  = cnt;
  assign bus.sync_err  = err;
  // a sof inside FILL restarts the frame; a sof-less byte in IDLE is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vin   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      err <= xfer && (state == IDLE ? !bus.sof : bus.sof);
      if (xfer && (bus.sof || state == FILL)) vin <= {bus.d_in, vin[N-1:W]};
      if (xfer && state == IDLE && bus.sof) begin
        state <= FILL;
        cnt   <= CW'(1);
      end else if (xfer && state == FILL) begin
        cnt <= bus.sof ? CW'(1) : cnt + CW'(1);
        if (!bus.sof && cnt == CW'(NB - 1)) state <= HOLD;
      end else if (state == HOLD && bus.v_ready) begin
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_data_in.sv
// tb_data_in: directed stimulus against a byte-queue model of frame assembly
module tb_data_in;
  localparam int N  = 9216;
  localparam int W  = 8;
  localparam int CW = 11;
  localparam int NB = N / W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  data_in_if #(.N(N), .W(W), .CW(CW)) bus ();
  data_in #(.N(N), .W(W), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int errs = 0;
  int checks = 0;
  int err_pulses = 0;
  logic [7:0]   frame[$];
  bit           holding, in_frame, exp_err;
  logic [N-1:0] exp_v;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // model: the current frame is just the list of bytes accepted since its sof
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame.delete();
      holding = 0;
      in_frame = 0;
      exp_err = 0;
    end else begin
      exp_err = 0;
      if (holding) begin
        if (bus.v_ready) begin
          holding = 0;
          in_frame = 0;
          frame.delete();
        end
      end else if (bus.din_valid) begin
        if (bus.sof) begin
          exp_err = in_frame;
          frame.delete();
          frame.push_back(bus.d_in);
          in_frame = 1;
        end else if (!in_frame) exp_err = 1;
        else begin
          frame.push_back(bus.d_in);
          if (frame.size() == NB) begin
            holding = 1;
            for (int k = 0; k < NB; k++) exp_v[8*k +: 8] = frame[k];
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("din_ready", bus.din_ready, !holding);
      chk("v_valid", bus.v_valid, holding);
      chk("count_in", bus.count_in, frame.size());
      chk("sync_err", bus.sync_err, exp_err);
      if (holding) chk("v_in_match", bus.v_in === exp_v, 1);
      if (bus.sync_err) err_pulses++;
    end
  end
  function automatic logic [7:0] pb(input int pat, input int k);
    logic [31:0] kk;
    kk = k;
    return pat == 0 ? kk[7:0] : pat == 1 ? 8'(k * 3 + 1) : kk[7:0] ^ 8'h5A;
  endfunction
  task automatic send(input logic [7:0] d, input logic s, input bit gap);
    if (gap && $urandom_range(0, 1) == 1) begin
      @(posedge clk);
      #1;
    end
    bus.din_valid = 1'b1;
    bus.d_in = d;
    bus.sof = s;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    bus.sof = 1'b0;
  endtask
  task automatic send_frame(input int n, input int pat, input bit gap, input bit first_sof);
    for (int k = 0; k < n; k++) send(pb(pat, k), first_sof && k == 0, gap);
  endtask
  task automatic handoff();
    bus.v_ready = 1'b1;
    bus.din_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.v_ready = 1'b0;
  endtask
  initial begin
    bus.din_valid = 1'b0;
    bus.sof = 1'b0;
    bus.d_in = '0;
    bus.v_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_din_ready", bus.din_ready, 1);
    chk("rst_v_valid", bus.v_valid, 0);
    chk("rst_count", bus.count_in, 0);
    chk("rst_sync_err", bus.sync_err, 0);
    chk("rst_v_in_zero", bus.v_in == '0, 1);
    rst_n = 1'b1;
    err_pulses = 0;
    send_frame(NB, 0, 0, 1);
    @(negedge clk);
    chk("f1_v_valid", bus.v_valid, 1);
    chk("f1_byte0", bus.v_in[7:0], 8'h00);
    chk("f1_byte1", bus.v_in[15:8], 8'h01);
    chk("f1_byte_last", bus.v_in[9215:9208], 8'h7F);
    chk("f1_count", bus.count_in, 1152);
    chk("f1_no_err", err_pulses, 0);
    for (int i = 0; i < 20; i++) begin
      bus.din_valid = 1'b1;
      bus.d_in = 8'($urandom);
      bus.sof = 1'($urandom);
      @(posedge clk);
      #1;
    end
    bus.sof = 1'b0;
    @(negedge clk);
    chk("hold_din_ready", bus.din_ready, 0);
    chk("hold_byte0", bus.v_in[7:0], 8'h00);
    chk("hold_byte_last", bus.v_in[9215:9208], 8'h7F);
    chk("hold_count", bus.count_in, 1152);
    handoff();
    @(negedge clk);
    chk("ho_count", bus.count_in, 0);
    chk("ho_din_ready", bus.din_ready, 1);
    err_pulses = 0;
    for (int i = 0; i < 3; i++) send(8'hEE, 1'b0, 0);
    send_frame(NB, 1, 0, 1);
    @(negedge clk);
    chk("idle_err_pulses", err_pulses, 3);
    chk("idle_byte0", bus.v_in[7:0], 8'h01);
    chk("idle_byte1", bus.v_in[15:8], 8'h04);
    handoff();
    send_frame(500, 0, 0, 1);
    send(8'hA5, 1'b1, 0);
    @(negedge clk);
    chk("resync_err", bus.sync_err, 1);
    chk("resync_count", bus.count_in, 1);
    send_frame(NB - 1, 0, 0, 0);
    @(negedge clk);
    chk("resync_byte0", bus.v_in[7:0], 8'hA5);
    chk("resync_v_valid", bus.v_valid, 1);
    handoff();
    err_pulses = 0;
    send_frame(NB - 1, 0, 1, 1);
    @(negedge clk);
    chk("gap_not_yet_valid", bus.v_valid, 0);
    send(pb(0, NB - 1), 1'b0, 1);
    @(negedge clk);
    chk("gap_v_valid", bus.v_valid, 1);
    chk("gap_byte0", bus.v_in[7:0], 8'h00);
    chk("gap_byte_last", bus.v_in[9215:9208], 8'h7F);
    chk("gap_no_err", err_pulses, 0);
    handoff();
    send_frame(700, 1, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_count", bus.count_in, 0);
    chk("arst_v_valid", bus.v_valid, 0);
    chk("arst_v_in_zero", bus.v_in == '0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(NB, 2, 0, 1);
    @(negedge clk);
    chk("fresh_byte0", bus.v_in[7:0], 8'h5A);
    chk("fresh_byte1", bus.v_in[15:8], 8'h5B);
    chk("fresh_v_valid", bus.v_valid, 1);
    handoff();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
